// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the write-back stage.
//   mem_wb_t      : MEM/WB pipeline bundle (valid_nop only used when WB_INSTRET_EN is defined)
//   RESULT_*      : encodings of mem_wb_t.resultsrc
//   FUNCT3_*      : load-width encodings of mem_wb_t.funct3
//   hold_state_e  : read-data hold FSM states
package wb_stage_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] RESULT_ALU  = 2'b00;
    localparam logic [1:0] RESULT_MEM  = 2'b01;
    localparam logic [1:0] RESULT_PC4  = 2'b10;
    localparam logic [1:0] RESULT_ZERO = 2'b11;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

    typedef struct packed {
        logic [XLEN-1:0] aluresult;
        logic [4:0]      rd;
        logic [XLEN-1:0] pcplus4;
        logic            regwrite;
        logic [1:0]      resultsrc;
        logic [2:0]      funct3;
        logic            valid_nop;  // retires without writing a register
    } mem_wb_t;

    typedef enum logic {
        StLive = 1'b0,
        StHeld = 1'b1
    } hold_state_e;

endpackage

// File: rtl/wb_stage_if.sv
// Bundle between the memory stage / hazard unit and the write-back stage.
//   i_stall, i_flush : hazard-unit controls
//   i_in             : mem_wb_t bundle from the memory stage
//   i_readdata       : synchronous data-memory read word
//   o_rd, o_regwrite : register-file write port address / enable
//   o_result         : write-back value, also the forwarding source
//   o_instret        : retired-instruction count (only with WB_INSTRET_EN)
// Modports: master (memory stage side), slave (wb_stage).
interface wb_stage_if;
    import wb_stage_pkg::*;

    logic            i_stall;
    logic            i_flush;
    mem_wb_t         i_in;
    logic [XLEN-1:0] i_readdata;
    logic [4:0]      o_rd;
    logic            o_regwrite;
    logic [XLEN-1:0] o_result;
`ifdef WB_INSTRET_EN
    logic [63:0]     o_instret;
`endif

    modport master (
        output i_stall, i_flush, i_in, i_readdata,
`ifdef WB_INSTRET_EN
        input  o_instret,
`endif
        input  o_rd, o_regwrite, o_result
    );

    modport slave (
        input  i_stall, i_flush, i_in, i_readdata,
`ifdef WB_INSTRET_EN
        output o_instret,
`endif
        output o_rd, o_regwrite, o_result
    );

endinterface

// File: rtl/wb_stage_load_extend.sv
// Combinational load-data extraction (load_extend).
//   i_word   : 32-bit memory word
//   i_off    : byte offset, low two address bits
//   i_funct3 : load width / signedness
//   o_value  : extracted, sign- or zero-extended value
// Misaligned offsets are truncated, never trapped: halfwords use only i_off[1],
// words ignore i_off; unknown funct3 values pass the whole word.
module wb_stage_load_extend
    import wb_stage_pkg::*;
(
    input  logic [XLEN-1:0] i_word,
    input  logic [1:0]      i_off,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_value
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        unique case (i_off)
            2'd0: w_byte = i_word[7:0];
            2'd1: w_byte = i_word[15:8];
            2'd2: w_byte = i_word[23:16];
            2'd3: w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
    end

    assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_value = i_word;
        case (i_funct3)
            FUNCT3_LB:  o_value = {{24{w_byte[7]}}, w_byte};
            FUNCT3_LBU: o_value = {24'd0, w_byte};
            FUNCT3_LH:  o_value = {{16{w_half[15]}}, w_half};
            FUNCT3_LHU: o_value = {16'd0, w_half};
            default:    o_value = i_word;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage of the five-stage RV32I pipeline.
//   clk    : pipeline clock
//   reset  : synchronous, active-high
//   io_wb  : wb_stage_if.slave (stall/flush, mem_wb_t bundle, BRAM read word,
//            rd/regwrite/result outputs, optional instret)
// Holds the MEM/WB register, freezes the BRAM read word across stalls, extracts
// load data and selects the architectural result.
// Optional feature macro: WB_INSTRET_EN adds a 64-bit retired-instruction counter.
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    wb_stage_if.slave io_wb
);

    mem_wb_t         r_q;
    hold_state_e     r_state;
    hold_state_e     w_state_next;
    logic            w_capture;
    logic [XLEN-1:0] r_hold;
    logic [XLEN-1:0] w_load_word;
    logic [XLEN-1:0] w_load_value;
    logic [XLEN-1:0] w_result;

    // MEM/WB register: reset > flush > stall > load
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (io_wb.i_flush) begin
            r_q <= '0;
        end else if (!io_wb.i_stall) begin
            r_q <= io_wb.i_in;
        end
    end

    // The memory stage keeps issuing reads while stalled, so the BRAM word seen
    // on the first stalled cycle is the one that belongs to the instruction in q.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StLive;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        if (io_wb.i_flush) begin
            w_state_next = StLive;
        end else begin
            unique case (r_state)
                StLive: begin
                    if (io_wb.i_stall) begin
                        w_state_next = StHeld;
                        w_capture    = 1'b1;
                    end
                end
                StHeld: begin
                    if (!io_wb.i_stall) begin
                        w_state_next = StLive;
                    end
                end
                default: w_state_next = StLive;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold <= '0;
        end else if (w_capture) begin
            r_hold <= io_wb.i_readdata;
        end
    end

    assign w_load_word = (r_state == StHeld) ? r_hold : io_wb.i_readdata;

    wb_stage_load_extend u_load_extend (
        .i_word   (w_load_word),
        .i_off    (r_q.aluresult[1:0]),
        .i_funct3 (r_q.funct3),
        .o_value  (w_load_value)
    );

    always_comb begin
        w_result = '0;
        case (r_q.resultsrc)
            RESULT_ALU:  w_result = r_q.aluresult;
            RESULT_MEM:  w_result = w_load_value;
            RESULT_PC4:  w_result = r_q.pcplus4;
            RESULT_ZERO: w_result = '0;
            default:     w_result = '0;
        endcase
    end

    assign io_wb.o_result   = w_result;
    assign io_wb.o_rd       = r_q.rd;
    // x0 is hard-wired to zero, never write it
    assign io_wb.o_regwrite = r_q.regwrite & (r_q.rd != 5'd0);

`ifdef WB_INSTRET_EN
    logic [63:0] r_instret;

    // A stalled cycle keeps the same instruction in q, so it is counted once,
    // on the cycle the stall releases. Wraps naturally at 2^64.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instret <= '0;
        end else if (!io_wb.i_stall && (r_q.regwrite || r_q.valid_nop)) begin
            r_instret <= r_instret + 64'd1;
        end
    end

    assign io_wb.o_instret = r_instret;
`else
    logic w_unused_valid_nop;
    assign w_unused_valid_nop = r_q.valid_nop;
`endif

endmodule
